// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program counter with jump redirect and two-cycle branch resolve.
// Ports: CLK, RST (sync, active-high), stall, br_valid, br_pc, br_offset, R,
//   jmp, jmp_target in; PC, flush, busy out; taken_count out with BRANCH_COUNT_EN.
// Optional feature macro: BRANCH_COUNT_EN (saturating taken-branch counter).
module branch_pc_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [15:0] br_pc,
    input  logic [15:0] br_offset,
    input  logic        R,
    input  logic        jmp,
    input  logic [15:0] jmp_target,
`ifdef BRANCH_COUNT_EN
    output logic [15:0] taken_count,
`endif
    output logic [15:0] PC,
    output logic        flush,
    output logic        busy
);

    typedef enum logic {RUN, RESOLVE} state_t;

    state_t      state;
    logic [15:0] lat_pc;
    logic [15:0] lat_off;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            PC      <= 16'h0000;
            flush   <= 1'b0;
            busy    <= 1'b0;
            lat_pc  <= 16'h0000;
            lat_off <= 16'h0000;
        end else if (stall) begin
            flush <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (jmp) begin
                        PC    <= jmp_target;
                        flush <= 1'b1;
                    end else if (br_valid) begin
                        lat_pc  <= br_pc;
                        lat_off <= br_offset;
                        flush   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RESOLVE;
                    end else begin
                        PC    <= PC + 16'd1;
                        flush <= 1'b0;
                    end
                end
                RESOLVE: begin
                    // Carry out of the 16-bit sum is dropped on purpose.
                    if (R) begin
                        PC    <= lat_pc + lat_off;
                        flush <= 1'b1;
                    end else begin
                        PC    <= lat_pc + 16'd1;
                        flush <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            taken_count <= 16'h0000;
        end else if (!stall && state == RESOLVE && R &&
                     taken_count != 16'hFFFF) begin
            taken_count <= taken_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: scoreboard bench for branch_pc_unit.
// Driver feeds a reference model and queues expectations; a monitor compares.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [15:0] br_pc;
    logic [15:0] br_offset;
    logic        r;
    logic        jmp;
    logic [15:0] jmp_target;
    logic [15:0] pc;
    logic        flush;
    logic        busy;
    logic [15:0] taken_count;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] off;
    } br_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        flush;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model: a pending branch is simply an entry in a queue.
    br_t         pend[$];
    logic [15:0] m_pc = 16'h0000;
    logic        m_flush = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    branch_pc_unit dut (
        .CLK        (clk),
        .RST        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .R          (r),
        .jmp        (jmp),
        .jmp_target (jmp_target),
`ifdef BRANCH_COUNT_EN
        .taken_count(taken_count),
`endif
        .PC         (pc),
        .flush      (flush),
        .busy       (busy)
    );

`ifndef BRANCH_COUNT_EN
    assign taken_count = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp_v, $time);
        end
    endtask

    task automatic step(input logic i_rst, input logic i_stall,
                        input logic i_bv, input logic [15:0] i_bpc,
                        input logic [15:0] i_boff, input logic i_r,
                        input logic i_jmp, input logic [15:0] i_jt);
        br_t  b;
        exp_t e;
        @(negedge clk);
        rst = i_rst;
        stall = i_stall;
        br_valid = i_bv;
        br_pc = i_bpc;
        br_offset = i_boff;
        r = i_r;
        jmp = i_jmp;
        jmp_target = i_jt;
        if (i_rst) begin
            m_pc = 16'h0000;
            pend.delete();
            m_flush = 1'b0;
            m_cnt = 16'h0000;
        end else if (i_stall) begin
            m_flush = 1'b0;
        end else if (pend.size() == 0) begin
            if (i_jmp) begin
                m_pc = i_jt;
                m_flush = 1'b1;
            end else if (i_bv) begin
                pend.push_back('{pc: i_bpc, off: i_boff});
                m_flush = 1'b0;
            end else begin
                m_pc = 16'((int'(m_pc) + 1) % 65536);
                m_flush = 1'b0;
            end
        end else begin
            b = pend.pop_front();
            if (i_r) begin
                m_pc = 16'((int'(b.pc) + int'(b.off)) % 65536);
                m_flush = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_pc = 16'((int'(b.pc) + 1) % 65536);
                m_flush = 1'b0;
            end
        end
        e.pc = m_pc;
        e.flush = m_flush;
        e.busy = (pend.size() != 0);
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    endtask

    // Monitor: every cycle the DUT presents a PC; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", int'(pc), int'(e.pc));
                chk("flush", int'(flush), int'(e.flush));
                chk("busy", int'(busy), int'(e.busy));
`ifdef BRANCH_COUNT_EN
                chk("taken_count", int'(taken_count), int'(e.cnt));
`endif
            end
        end
    end

    initial begin
        int guard;
        rst = 1;
        stall = 0;
        br_valid = 0;
        br_pc = 0;
        br_offset = 0;
        r = 0;
        jmp = 0;
        jmp_target = 0;

        // Reset overrides stall and every other input.
        step(1, 1, 1, 16'hAAAA, 16'h5555, 1, 1, 16'hBEEF);
        step(1, 0, 1, 16'h1111, 16'h2222, 1, 1, 16'h3333);

        // Free running 1..5, then run up to 0x0010.
        guard = 0;
        while (m_pc != 16'h0010 && guard < 100) begin
            idle();
            guard++;
        end

        // Taken branch: 0x10 + 8; jmp/br_valid ignored while resolving.
        step(0, 0, 1, 16'h0010, 16'h0008, 0, 0, 16'h0);
        step(0, 0, 1, 16'h7777, 16'h7777, 1, 1, 16'h4444);
        idle();

        // Not taken: back to 0x10 by jump, then branch with R=0.
        step(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h0010);
        step(0, 0, 1, 16'h0010, 16'h0008, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        idle();

        // Negative offset wrap then PC increment wrap.
        step(0, 0, 1, 16'h0002, 16'hFFFC, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
        repeat (3) idle();

        // Jump wins over a simultaneous branch.
        step(0, 0, 1, 16'h0100, 16'h0020, 1, 1, 16'h1234);
        idle();

        // Stall in RESOLVE: R toggles but is ignored until stall drops.
        step(0, 0, 1, 16'h0200, 16'h0040, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0, 16'h0, 1, 1, 16'h9999);
        step(0, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0, 16'h0, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        idle();

        // Reset during RESOLVE abandons the branch.
        step(0, 0, 1, 16'h0300, 16'h0010, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
        repeat (2) idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 16'($urandom), 16'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 7) == 0),
                 16'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
